dual_port_ram_clr: RTL and testbench

Parametrised simple-dual-port RAM and successor to single_port_ram. It has one write port and one read port, byte-enable writes, and a selectable read latency of 1 or 2. It has a defined read-during-write policy and a hardware clear engine that zeroes every word after reset or on request. It serves as the generic on-chip buffer (weights, feature-map lines) for the convNet accelerator datapath.

---
 rtl/dual_port_ram_clr.sv | 199 +++++++++++++++++++
 tb/tb_dual_port_ram_clr.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_clr.sv
// ============================================================================
// Module   : dual_port_ram_clr
// Purpose  : Simple-dual-port byte-enable RAM with a hardware clear engine,
//            1- or 2-cycle read latency and selectable read-during-write result.
//            Define RAM_PARITY_EN to add per-byte even parity and parity_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram_clr #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 3,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid
`ifdef RAM_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int c_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int c_NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;
`ifdef RAM_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif
  localparam int c_PW = DATA_WIDTH + c_PAR;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem [c_DEPTH];

  logic                    wr_en;
  logic                    rd_en;
  logic                    rdw_hit;
  logic [DATA_WIDTH-1:0]   rd_word_d;
  logic [c_PW-1:0]         rd_pay_d;
  logic                    out_v;
  logic [c_PW-1:0]         out_pay;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [c_NBYTES-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < c_NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // User traffic is only honoured in IDLE; everything is ignored while clearing.
  assign wr_en   = we & (state_q == ST_IDLE);
  assign rd_en   = re & (state_q == ST_IDLE);
  assign rdw_hit = (RDW_MODE == 1) && wr_en && (waddr == raddr);
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= merge_bytes(mem[waddr], wdata, wbe);
    end
  end

  always_comb begin
    rd_word_d = mem[raddr];
    if (rdw_hit) rd_word_d = merge_bytes(mem[raddr], wdata, wbe);
  end

`ifdef RAM_PARITY_EN
  logic [c_NBYTES-1:0] par_mem [c_DEPTH];
  logic [c_NBYTES-1:0] rd_par_d;

  function automatic logic [c_NBYTES-1:0] par_of(input logic [DATA_WIDTH-1:0] w);
    logic [c_NBYTES-1:0] p;
    for (int i = 0; i < c_NBYTES; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      par_mem[waddr] <= (par_mem[waddr] & ~wbe) | (par_of(wdata) & wbe);
    end
  end

  always_comb begin
    rd_par_d = par_mem[raddr];
    if (rdw_hit) rd_par_d = (par_mem[raddr] & ~wbe) | (par_of(wdata) & wbe);
  end

  assign rd_pay_d = {|(par_of(rd_word_d) ^ rd_par_d), rd_word_d};
`else
  assign rd_pay_d = rd_word_d;
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic            s1_v_q;
      logic [c_PW-1:0] s1_pay_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v_q   <= 1'b0;
          s1_pay_q <= '0;
        end else begin
          s1_v_q <= rd_en;
          if (rd_en) s1_pay_q <= rd_pay_d;
        end
      end

      assign out_v   = s1_v_q;
      assign out_pay = s1_pay_q;
    end else begin : g_lat1
      assign out_v   = rd_en;
      assign out_pay = rd_pay_d;
    end
  endgenerate

  // rdata only moves on a valid read so it holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= out_v;
      if (out_v) rdata_q <= out_pay[DATA_WIDTH-1:0];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

`ifdef RAM_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= out_v & out_pay[c_PW-1];
  end

  assign parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_clr.sv
// Directed bench: instance A uses latency 1 / old-data RDW, instance B uses
// latency 2 / new-data RDW; both share the same stimulus.
`default_nettype none

module tb_dual_port_ram_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;

  logic        busy_a, rvalid_a, busy_b, rvalid_b;
  logic [31:0] rdata_a, rdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  dual_port_ram_clr u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
  );

  dual_port_ram_clr #(.READ_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    waddr = a; wdata = d; wbe = be; we = 1'b1;
    tick();
    we = 1'b0; wbe = '0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] ea, input logic [31:0] eb,
                        input string nm);
    raddr = a; re = 1'b1;
    tick();
    re = 1'b0;
    n_cmp++;
    if (rvalid_a !== 1'b1 || rdata_a !== ea) begin
      n_bad++;
      $display("FAIL %s_A addr=%0d: got v=%b d=%h, need v=1 d=%h", nm, a, rvalid_a, rdata_a, ea);
    end
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b1 || rdata_b !== eb) begin
      n_bad++;
      $display("FAIL %s_B addr=%0d: got v=%b d=%h, need v=1 d=%h", nm, a, rvalid_b, rdata_b, eb);
    end
    n_cmp++;
    if (rvalid_a !== 1'b0 || rdata_a !== ea) begin
      n_bad++;
      $display("FAIL %s_A_hold addr=%0d: got v=%b d=%h, need v=0 d=%h", nm, a, rvalid_a, rdata_a, ea);
    end
  endtask

  task automatic wait_clear(input int start, input int exp_n, input string nm);
    int n;
    logic seen;
    n = start;
    seen = 1'b0;
    while (busy_a && n < 30) begin
      tick();
      n++;
      if (rvalid_a || rvalid_b) seen = 1'b1;
    end
    n_cmp++;
    if (n != exp_n) begin
      n_bad++;
      $display("FAIL %s_len: got %0d cycles, need %0d", nm, n, exp_n);
    end
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busyB: got %b, need 0", nm, busy_b);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_rvalid_busy: got %b, need 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_busy: got %b, need 11", {busy_a, busy_b});
    end
    n_cmp++;
    if ({rvalid_a, rvalid_b} !== 2'b00 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b%b a=%h b=%h, need v=00 data 0",
               rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
    rst_n = 1'b1;
    wait_clear(0, 8, "reset_clear");
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, 32'h0, "post_reset_rd");
  endtask

  task automatic test_byte_enable();
    wr(3'd5, 32'hDEADBEEF, 4'hF);
    wr(3'd5, 32'h0000AA00, 4'b0010);
    rd_chk(3'd5, 32'hDEADAAEF, 32'hDEADAAEF, "byte_en");
    wr(3'd5, 32'h12345678, 4'h0);
    rd_chk(3'd5, 32'hDEADAAEF, 32'hDEADAAEF, "byte_en_none");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [5];
    logic [31:0] exp_b [5];
    logic [4:0]  va, vb;
    exp_a = '{32'h11, 32'h22, 32'h33, 32'h33, 32'h33};
    exp_b = '{32'hDEADAAEF, 32'h11, 32'h22, 32'h33, 32'h33};
    va = 5'b00111;
    vb = 5'b01110;
    wr(3'd1, 32'h11, 4'hF);
    wr(3'd2, 32'h22, 4'hF);
    wr(3'd3, 32'h33, 4'hF);
    for (int c = 0; c < 5; c++) begin
      re = (c < 3);
      raddr = 3'(c + 1);
      tick();
      n_cmp++;
      if (rvalid_a !== va[c] || rdata_a !== exp_a[c] || rvalid_b !== vb[c] || rdata_b !== exp_b[c]) begin
        n_bad++;
        $display("FAIL b2b cycle %0d: got A v=%b d=%h B v=%b d=%h, need A v=%b d=%h B v=%b d=%h",
                 c, rvalid_a, rdata_a, rvalid_b, rdata_b, va[c], exp_a[c], vb[c], exp_b[c]);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_rdw();
    wr(3'd4, 32'h12345678, 4'hF);
    waddr = 3'd4; raddr = 3'd4; wdata = 32'hCAFEF00D; wbe = 4'hF; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; wbe = '0;
    n_cmp++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h12345678) begin
      n_bad++;
      $display("FAIL rdw_old_A: got v=%b d=%h, need v=1 d=12345678", rvalid_a, rdata_a);
    end
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL rdw_new_B: got v=%b d=%h, need v=1 d=cafef00d", rvalid_b, rdata_b);
    end
    rd_chk(3'd4, 32'hCAFEF00D, 32'hCAFEF00D, "rdw_after");
    // Partial-byte collision: new-data mode must merge
    waddr = 3'd4; raddr = 3'd4; wdata = 32'h000000AA; wbe = 4'b0001; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; wbe = '0;
    n_cmp++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL rdw_part_A: got v=%b d=%h, need v=1 d=cafef00d", rvalid_a, rdata_a);
    end
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'hCAFEF0AA) begin
      n_bad++;
      $display("FAIL rdw_part_B: got v=%b d=%h, need v=1 d=cafef0aa", rvalid_b, rdata_b);
    end
    // Different addresses do not interact
    waddr = 3'd6; raddr = 3'd5; wdata = 32'h66666666; wbe = 4'hF; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; wbe = '0;
    n_cmp++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEADAAEF) begin
      n_bad++;
      $display("FAIL rdw_diff_A: got v=%b d=%h, need v=1 d=deadaaef", rvalid_a, rdata_a);
    end
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'hDEADAAEF) begin
      n_bad++;
      $display("FAIL rdw_diff_B: got v=%b d=%h, need v=1 d=deadaaef", rvalid_b, rdata_b);
    end
    rd_chk(3'd6, 32'h66666666, 32'h66666666, "rdw_diff_wr");
  endtask

  task automatic test_clear();
    for (int a = 0; a < 8; a++) wr(3'(a), 32'hFFFFFFFF, 4'hF);
    clr = 1'b1; re = 1'b1; raddr = 3'd5;
    tick();
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b11 || rvalid_a !== 1'b1 || rdata_a !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL clr_start: got busy=%b%b A v=%b d=%h, need busy=11 A v=1 d=ffffffff",
               busy_a, busy_b, rvalid_a, rdata_a);
    end
    // Traffic while busy must be ignored
    we = 1'b1; waddr = 3'd2; wdata = 32'h12345678; wbe = 4'hF; raddr = 3'd3;
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'hFFFFFFFF || rvalid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_drain: got B v=%b d=%h A v=%b, need B v=1 d=ffffffff A v=0",
               rvalid_b, rdata_b, rvalid_a);
    end
    wait_clear(2, 9, "clr");
    we = 1'b0; re = 1'b0; clr = 1'b0; wbe = '0;
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, 32'h0, "post_clr_rd");
  endtask

  task automatic test_reset_mid();
    wr(3'd1, 32'hA5A5A5A5, 4'hF);
    clr = 1'b1; re = 1'b1; raddr = 3'd1;
    tick();
    clr = 1'b0; re = 1'b0;
    n_cmp++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL rst_mid_pre: got v=%b d=%h, need v=1 d=a5a5a5a5", rvalid_a, rdata_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 || {busy_a, busy_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_mid_async: got v=%b d=%h busy=%b%b, need v=0 d=0 busy=11",
               rvalid_a, rdata_a, busy_a, busy_b);
    end
    tick();
    n_cmp++;
    if (rvalid_b !== 1'b0 || rdata_b !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_drop_B: got v=%b d=%h, need v=0 d=0", rvalid_b, rdata_b);
    end
    tick();
    rst_n = 1'b1;
    wait_clear(0, 8, "rst_read");
    // Reset three cycles into a clear
    for (int a = 0; a < 8; a++) wr(3'(a), 32'h5A5A5A5A, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_clear(0, 8, "rst_clear");
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, 32'h0, "rst_clear_rd");
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_rdw();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
